// File: rtl/wb_exp_ctrl.sv
// Writeback stage: GPR write, control-register file, exception/interrupt entry and EXRT return.
// Latency: flush/new_pc/gpr write strobe are combinational; control-register updates land at the next edge.
// Backpressure: stall=1 freezes every state update and suppresses flush; pending irq stays pending.
module wb_exp_ctrl #(
    parameter logic [29:0] EXC_VECTOR = 30'h0,
    parameter int          IRQ_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [29:0]      mem_pc,
    input  logic             mem_en,
    input  logic             mem_br_flag,
    input  logic [1:0]       mem_ctrl_op,
    input  logic [4:0]       mem_dst_addr,
    input  logic             mem_gpr_we_,
    input  logic [2:0]       mem_exp_code,
    input  logic [31:0]      mem_out,
    input  logic [IRQ_W-1:0] irq,
    input  logic [4:0]       cr_rd_addr,
    output logic [31:0]      cr_rd_data,
    output logic             gpr_we_,
    output logic [4:0]       gpr_wr_addr,
    output logic [31:0]      gpr_wr_data,
    output logic             flush,
    output logic [29:0]      new_pc,
    output logic             exe_mode,
    output logic             int_en
);

    localparam logic [1:0] OP_WRCR     = 2'd1;
    localparam logic [1:0] OP_EXRT     = 2'd2;
    localparam logic [4:0] CR_STATUS   = 5'd0;
    localparam logic [4:0] CR_INT_MASK = 5'd1;
    localparam logic [4:0] CR_EXP_CODE = 5'd2;
    localparam logic [4:0] CR_EPC      = 5'd3;
    localparam logic [2:0] CODE_EXT_INT = 3'd1;

    logic             mode, ie, pre_mode, pre_ie;
    logic [IRQ_W-1:0] int_mask;
    logic [29:0]      epc;
    logic [2:0]       exp_code;

    logic             active, exc_ev, int_ev, trap_ev, exrt_ev, wrcr_ev;
    logic [29:0]      ret_pc;
    logic [31:0]      mask_ext;

    assign exe_mode    = mode;
    assign int_en      = ie;
    assign gpr_wr_addr = mem_dst_addr;
    assign gpr_wr_data = mem_out;

    // Event decode; reset is folded in so flush/gpr_we_/new_pc sit at their idle values while reset is held.
    always_comb begin
        active  = reset & mem_en & ~stall;
        exc_ev  = active & (mem_exp_code != 3'd0);
        int_ev  = active & ~exc_ev & ie & (|(irq & ~int_mask));
        trap_ev = exc_ev | int_ev;
        exrt_ev = active & ~trap_ev & (mem_ctrl_op == OP_EXRT);
        wrcr_ev = active & ~trap_ev & (mem_ctrl_op == OP_WRCR);
        flush   = trap_ev | exrt_ev;
        new_pc  = trap_ev ? EXC_VECTOR : (exrt_ev ? epc : 30'h0);
        gpr_we_ = ~(active & ~mem_gpr_we_ & ~trap_ev);
        // A delay-slot instruction restarts at its branch so the branch is re-taken.
        ret_pc  = mem_br_flag ? (mem_pc - 30'd1) : mem_pc;
    end

    // Control-register read port; reads see pre-update values (no write bypass).
    always_comb begin
        mask_ext              = 32'h0;
        mask_ext[IRQ_W-1:0]   = int_mask;
        case (cr_rd_addr)
            CR_STATUS:   cr_rd_data = {28'h0, pre_ie, pre_mode, ie, mode};
            CR_INT_MASK: cr_rd_data = mask_ext;
            CR_EXP_CODE: cr_rd_data = {29'h0, exp_code};
            CR_EPC:      cr_rd_data = {epc, 2'b00};
            default:     cr_rd_data = 32'h0;
        endcase
    end

    // Control-register state: trap entry beats EXRT, which beats WRCR; all gated by active.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode     <= 1'b0;
            ie       <= 1'b0;
            pre_mode <= 1'b0;
            pre_ie   <= 1'b0;
            int_mask <= '1;
            epc      <= 30'h0;
            exp_code <= 3'd0;
        end else if (trap_ev) begin
            epc      <= ret_pc;
            exp_code <= exc_ev ? mem_exp_code : CODE_EXT_INT;
            pre_mode <= mode;
            pre_ie   <= ie;
            mode     <= 1'b0;
            ie       <= 1'b0;
        end else if (exrt_ev) begin
            mode     <= pre_mode;
            ie       <= pre_ie;
        end else if (wrcr_ev) begin
            case (mem_dst_addr)
                CR_STATUS: begin
                    mode     <= mem_out[0];
                    ie       <= mem_out[1];
                    pre_mode <= mem_out[2];
                    pre_ie   <= mem_out[3];
                end
                CR_INT_MASK: int_mask <= mem_out[IRQ_W-1:0];
                CR_EXP_CODE: exp_code <= mem_out[2:0];
                CR_EPC:      epc      <= mem_out[31:2];
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_exp_ctrl.sv
module tb_wb_exp_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [29:0] mem_pc;
    logic        mem_en;
    logic        mem_br_flag;
    logic [1:0]  mem_ctrl_op;
    logic [4:0]  mem_dst_addr;
    logic        mem_gpr_we_;
    logic [2:0]  mem_exp_code;
    logic [31:0] mem_out;
    logic [7:0]  irq;
    logic [4:0]  cr_rd_addr;
    logic [31:0] cr_rd_data;
    logic        gpr_we_;
    logic [4:0]  gpr_wr_addr;
    logic [31:0] gpr_wr_data;
    logic        flush;
    logic [29:0] new_pc;
    logic        exe_mode;
    logic        int_en;

    int checks   = 0;
    int failures = 0;

    // Reference model: the four control registers as they read back on the bus.
    logic [31:0] cr [4];
    logic [31:0] wmask [4];

    wb_exp_ctrl #(.EXC_VECTOR(30'h0), .IRQ_W(8)) dut (
        .clk(clk), .reset(reset), .stall(stall), .mem_pc(mem_pc), .mem_en(mem_en),
        .mem_br_flag(mem_br_flag), .mem_ctrl_op(mem_ctrl_op), .mem_dst_addr(mem_dst_addr),
        .mem_gpr_we_(mem_gpr_we_), .mem_exp_code(mem_exp_code), .mem_out(mem_out), .irq(irq),
        .cr_rd_addr(cr_rd_addr), .cr_rd_data(cr_rd_data), .gpr_we_(gpr_we_),
        .gpr_wr_addr(gpr_wr_addr), .gpr_wr_data(gpr_wr_data), .flush(flush), .new_pc(new_pc),
        .exe_mode(exe_mode), .int_en(int_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        cr[0] = 32'h0; cr[1] = 32'hFF; cr[2] = 32'h0; cr[3] = 32'h0;
    endtask

    task automatic drv(input logic en, input logic stl, input logic [29:0] pc, input logic br,
                       input logic [1:0] op, input logic [4:0] dst, input logic gwe,
                       input logic [2:0] code, input logic [31:0] dat, input logic [7:0] rq,
                       input logic [4:0] rda);
        mem_en = en; stall = stl; mem_pc = pc; mem_br_flag = br; mem_ctrl_op = op;
        mem_dst_addr = dst; mem_gpr_we_ = gwe; mem_exp_code = code; mem_out = dat;
        irq = rq; cr_rd_addr = rda;
    endtask

    // Called at a negedge with inputs applied; checks outputs, advances the model across one posedge.
    task automatic cycle();
        logic act, ex, it, tr, er, wr;
        logic [31:0] s, exp_rd;
        logic [29:0] p;
        #1;
        s  = cr[0];
        act = reset && mem_en && !stall;
        ex = act && (mem_exp_code != 3'd0);
        it = act && !ex && s[1] && ((irq & ~cr[1][7:0]) != 8'h0);
        tr = ex || it;
        er = act && !tr && (mem_ctrl_op == 2'd2);
        wr = act && !tr && (mem_ctrl_op == 2'd1);
        exp_rd = (cr_rd_addr < 5'd4) ? cr[cr_rd_addr[1:0]] : 32'h0;
        chk("flush", {31'h0, flush}, {31'h0, tr || er});
        chk("new_pc", {2'b0, new_pc}, tr ? 32'h0 : (er ? (cr[3] >> 2) : 32'h0));
        chk("gpr_we_", {31'h0, gpr_we_}, {31'h0, !(act && !mem_gpr_we_ && !tr)});
        chk("gpr_wr_addr", {27'h0, gpr_wr_addr}, {27'h0, mem_dst_addr});
        chk("gpr_wr_data", gpr_wr_data, mem_out);
        chk("cr_rd_data", cr_rd_data, exp_rd);
        chk("exe_mode", {31'h0, exe_mode}, {31'h0, s[0]});
        chk("int_en", {31'h0, int_en}, {31'h0, s[1]});
        @(posedge clk);
        if (tr) begin
            p = mem_br_flag ? mem_pc - 30'd1 : mem_pc;
            cr[3] = {p, 2'b00};
            cr[2] = ex ? {29'h0, mem_exp_code} : 32'h1;
            cr[0] = {28'h0, s[1:0], 2'b00};
        end else if (er) begin
            cr[0] = {28'h0, s[3:2], s[3:2]};
        end else if (wr && mem_dst_addr < 5'd4) begin
            cr[mem_dst_addr[1:0]] = mem_out & wmask[mem_dst_addr[1:0]];
        end
        @(negedge clk);
    endtask

    initial begin
        wmask[0] = 32'hF; wmask[1] = 32'hFF; wmask[2] = 32'h7; wmask[3] = 32'hFFFF_FFFC;
        model_reset();
        reset = 1'b0;
        drv(1, 0, 30'h10, 0, 2'd0, 5'd0, 0, 3'd3, 32'h0, 8'hFF, 5'd1);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_flush", {31'h0, flush}, 32'h0);
        chk("rst_gpr_we_", {31'h0, gpr_we_}, 32'h1);
        chk("rst_new_pc", {2'b0, new_pc}, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // 1: reset values
        drv(0, 0, 30'h0, 0, 2'd0, 5'd0, 1, 3'd0, 32'h0, 8'h0, 5'd0);
        #1 chk("t1_status", cr_rd_data, 32'h0);
        cr_rd_addr = 5'd1;
        #1 chk("t1_mask", cr_rd_data, 32'h0000_00FF);
        chk("t1_flush", {31'h0, flush}, 32'h0);
        chk("t1_gpr_we_", {31'h0, gpr_we_}, 32'h1);
        cycle();

        // 2: plain GPR write
        drv(1, 0, 30'h4, 0, 2'd0, 5'd5, 0, 3'd0, 32'hCAFE_0001, 8'h0, 5'd0);
        #1 chk("t2_gpr_we_", {31'h0, gpr_we_}, 32'h0);
        chk("t2_flush", {31'h0, flush}, 32'h0);
        cycle();

        // 3: overflow in delay slot
        drv(1, 0, 30'h100, 1, 2'd0, 5'd7, 0, 3'd3, 32'h1234, 8'h0, 5'd3);
        #1 chk("t3_flush", {31'h0, flush}, 32'h1);
        chk("t3_gpr_we_", {31'h0, gpr_we_}, 32'h1);
        cycle();
        drv(0, 0, 30'h0, 0, 2'd0, 5'd0, 1, 3'd0, 32'h0, 8'h0, 5'd3);
        #1 chk("t3_epc", cr_rd_data, 32'h0000_03FC);
        cr_rd_addr = 5'd2;
        #1 chk("t3_code", cr_rd_data, 32'h3);
        chk("t3_mode", {31'h0, exe_mode}, 32'h0);
        cycle();

        // 4: interrupt with stall gating
        drv(1, 0, 30'h20, 0, 2'd1, 5'd0, 1, 3'd0, 32'h3, 8'h0, 5'd0);
        cycle();
        drv(1, 0, 30'h21, 0, 2'd1, 5'd1, 1, 3'd0, 32'hFE, 8'h0, 5'd0);
        cycle();
        drv(1, 1, 30'h22, 0, 2'd0, 5'd2, 0, 3'd0, 32'h0, 8'h01, 5'd0);
        #1 chk("t4_stall_flush", {31'h0, flush}, 32'h0);
        cycle();
        cycle();
        stall = 1'b0;
        #1 chk("t4_flush", {31'h0, flush}, 32'h1);
        cycle();
        drv(0, 0, 30'h0, 0, 2'd0, 5'd0, 1, 3'd0, 32'h0, 8'h0, 5'd0);
        #1 chk("t4_status", cr_rd_data, 32'hC);
        cr_rd_addr = 5'd2;
        #1 chk("t4_code", cr_rd_data, 32'h1);
        cycle();

        // 5: EXRT to epc 0x40
        drv(1, 0, 30'h30, 0, 2'd1, 5'd3, 1, 3'd0, 32'h100, 8'h0, 5'd3);
        cycle();
        drv(1, 0, 30'h31, 0, 2'd2, 5'd0, 1, 3'd0, 32'h0, 8'h0, 5'd0);
        #1 chk("t5_flush", {31'h0, flush}, 32'h1);
        chk("t5_new_pc", {2'b0, new_pc}, 32'h40);
        cycle();
        drv(0, 0, 30'h0, 0, 2'd0, 5'd0, 1, 3'd0, 32'h0, 8'h0, 5'd0);
        #1 chk("t5_mode", {31'h0, exe_mode}, 32'h1);
        chk("t5_ie", {31'h0, int_en}, 32'h1);
        cycle();

        // 6: exception beats EXRT, then reset lands mid-event
        drv(1, 0, 30'h50, 0, 2'd2, 5'd0, 0, 3'd4, 32'h0, 8'h0, 5'd0);
        #1 chk("t6_flush", {31'h0, flush}, 32'h1);
        chk("t6_new_pc", {2'b0, new_pc}, 32'h0);
        reset = 1'b0;
        model_reset();
        #1 chk("t6_rst_flush", {31'h0, flush}, 32'h0);
        chk("t6_rst_gpr_we_", {31'h0, gpr_we_}, 32'h1);
        @(posedge clk);
        #1;
        for (int a = 0; a < 4; a++) begin
            cr_rd_addr = 5'(a);
            #1 chk("t6_cr_reset", cr_rd_data, cr[a]);
        end
        @(negedge clk);
        reset = 1'b1;

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            drv(($urandom_range(0, 4) != 0), ($urandom_range(0, 4) == 0), 30'($urandom),
                1'($urandom), 2'($urandom),
                ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 4)) : 5'($urandom),
                1'($urandom), ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 6)) : 3'd0,
                $urandom, ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h0,
                5'($urandom_range(0, 5)));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
